// File: rtl/mlp_pkg.sv
// mlp_pkg: shared sizes, state encoding and beat tag for the MLP load sequencer.
package mlp_pkg;
   localparam int NUM_LAYERS = 8;
   localparam int ROWS       = 16;
   localparam int BEATS_ROW  = 8;
   localparam int K_W        = $clog2(BEATS_ROW);
   localparam int ROW_W      = $clog2(ROWS);
   localparam int LAYER_W    = $clog2(NUM_LAYERS);
   localparam int IN_AW      = ROW_W + K_W;
   localparam int WT_AW      = LAYER_W + IN_AW;
   typedef enum logic [2:0] {IDLE, L0_IN, L0_WT, LN_WT, FLUSH} seq_state_t;
   typedef struct packed {
      logic               valid;
      logic               in_beat;
      logic [ROW_W-1:0]   row;
      logic [LAYER_W-1:0] layer;
      logic [K_W-1:0]     wnum;
   } beat_tag_t;
endpackage

// File: rtl/mlp_load_addr_gen.sv
// mlp_load_addr_gen: nested k/w, row and layer counters driving the two SRAM read ports.
module mlp_load_addr_gen
   import mlp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue,
   output logic             in_rd_en,
   output logic [IN_AW-1:0] in_rd_addr,
   output logic             wt_rd_en,
   output logic [WT_AW-1:0] wt_rd_addr,
   output logic             next_in,
   output logic             next_layer0,
   output logic             last_beat
);
   logic [K_W-1:0]     k;
   logic [ROW_W-1:0]   row, row_nx;
   logic [LAYER_W-1:0] layer, layer_nx;
   logic               in_phase, k_wrap, row_wrap, layer_wrap;
   always_comb begin
      k_wrap      = k == K_W'(BEATS_ROW - 1);
      row_wrap    = k_wrap & ~in_phase;
      layer_wrap  = row_wrap & (row == ROW_W'(ROWS - 1));
      row_nx      = row_wrap ? (layer_wrap ? '0 : row + 1'b1) : row;
      layer_nx    = layer_wrap ? (layer == LAYER_W'(NUM_LAYERS - 1) ? '0 : layer + 1'b1) : layer;
      next_layer0 = layer_nx == '0;
      // layer 0 alternates input and weight rows; the final wrap lands back on input row 0
      next_in     = k_wrap ? (in_phase ? 1'b0 : next_layer0) : in_phase;
      last_beat   = layer_wrap & (layer == LAYER_W'(NUM_LAYERS - 1));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_rd_en   <= 1'b0;
         wt_rd_en   <= 1'b0;
         in_rd_addr <= '0;
         wt_rd_addr <= '0;
         k          <= '0;
         row        <= '0;
         layer      <= '0;
         in_phase   <= 1'b1;
      end else begin
         in_rd_en <= issue & in_phase;
         wt_rd_en <= issue & ~in_phase;
         if (issue) begin
            if (in_phase) in_rd_addr <= {row, k};
            else wt_rd_addr <= {layer, row, k};
            k        <= k_wrap ? '0 : k + 1'b1;
            row      <= row_nx;
            layer    <= layer_nx;
            in_phase <= next_in;
         end
      end
   end
endmodule

// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer: streams one input matrix and all weight layers from SRAM as load_* beats.
module mlp_load_sequencer
   import mlp_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               in_rd_en_o,
   output logic [IN_AW-1:0]   in_rd_addr_o,
   input  logic [31:0]        in_rd_data_i,
   output logic               wt_rd_en_o,
   output logic [WT_AW-1:0]   wt_rd_addr_o,
   input  logic [31:0]        wt_rd_data_i,
   output logic               load_en_o,
   output logic [31:0]        load_payload_o,
   output logic               load_type_o,
   output logic [ROW_W-1:0]   input_load_number_o,
   output logic [LAYER_W-1:0] layer_number_o,
   output logic [K_W-1:0]     weight_number_o
);
   seq_state_t state;
   beat_tag_t  tag;
   logic       issue, next_in, next_layer0, last_beat;
   always_comb issue = (state == IDLE & start_i) | state == L0_IN | state == L0_WT | state == LN_WT;
   mlp_load_addr_gen u_addr (
      .clk(clk),
      .rst_n(rst_n),
      .issue(issue),
      .in_rd_en(in_rd_en_o),
      .in_rd_addr(in_rd_addr_o),
      .wt_rd_en(wt_rd_en_o),
      .wt_rd_addr(wt_rd_addr_o),
      .next_in(next_in),
      .next_layer0(next_layer0),
      .last_beat(last_beat)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         busy_o              <= 1'b0;
         done_o              <= 1'b0;
         tag                 <= '0;
         load_en_o           <= 1'b0;
         load_payload_o      <= '0;
         load_type_o         <= 1'b0;
         input_load_number_o <= '0;
         layer_number_o      <= '0;
         weight_number_o     <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: if (start_i) begin
               state  <= L0_IN;
               busy_o <= 1'b1;
            end
            L0_IN, L0_WT, LN_WT: state <= last_beat ? FLUSH : next_in ? L0_IN : next_layer0 ? L0_WT : LN_WT;
            // the last beat is on the outputs once the tag stage has emptied
            FLUSH: if (load_en_o & ~tag.valid) begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
         // the held address of the idle port is irrelevant; only the enabled port describes the beat
         tag.valid   <= in_rd_en_o | wt_rd_en_o;
         tag.in_beat <= in_rd_en_o;
         tag.row     <= in_rd_en_o ? in_rd_addr_o[IN_AW-1:K_W] : wt_rd_addr_o[IN_AW-1:K_W];
         tag.layer   <= in_rd_en_o ? '0 : wt_rd_addr_o[WT_AW-1:IN_AW];
         tag.wnum    <= in_rd_en_o ? '0 : wt_rd_addr_o[K_W-1:0];
         load_en_o       <= tag.valid;
         load_payload_o  <= tag.valid ? (tag.in_beat ? in_rd_data_i : wt_rd_data_i) : '0;
         load_type_o     <= tag.valid & tag.in_beat;
         weight_number_o <= tag.valid ? tag.wnum : '0;
         if (tag.valid) begin
            input_load_number_o <= tag.row;
            layer_number_o      <= tag.layer;
         end
      end
   end
endmodule

// File: tb/tb_mlp_load_sequencer.sv
// tb_mlp_load_sequencer: scoreboard bench with SRAM models for the load sequencer.
module tb_mlp_load_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
   logic        busy_o, done_o, in_rd_en_o, wt_rd_en_o, load_en_o, load_type_o;
   logic [6:0]  in_rd_addr_o;
   logic [9:0]  wt_rd_addr_o;
   logic [31:0] in_rd_data_i, wt_rd_data_i, load_payload_o;
   logic [3:0]  input_load_number_o;
   logic [2:0]  layer_number_o, weight_number_o;
   logic [31:0] in_mem [128];
   logic [31:0] wt_mem [1024];
   typedef struct packed {
      logic [31:0] payload;
      logic        typ;
      logic [3:0]  row;
      logic [2:0]  layer;
      logic [2:0]  wnum;
   } beat_t;
   typedef struct packed {
      logic       typ;
      logic [9:0] addr;
   } rd_t;
   beat_t exp_q[$];
   rd_t   rd_q[$];
   int    checks = 0, failures = 0, cyc = 0, beat_idx = 0, rd_idx = 0, t0 = 0, first_cyc = 0, done_cyc = 0;
   bit    done_seen = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (in_rd_en_o) in_rd_data_i <= in_mem[in_rd_addr_o];
      if (wt_rd_en_o) wt_rd_data_i <= wt_mem[wt_rd_addr_o];
   end

   mlp_load_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .in_rd_en_o(in_rd_en_o), .in_rd_addr_o(in_rd_addr_o), .in_rd_data_i(in_rd_data_i),
      .wt_rd_en_o(wt_rd_en_o), .wt_rd_addr_o(wt_rd_addr_o), .wt_rd_data_i(wt_rd_data_i),
      .load_en_o(load_en_o), .load_payload_o(load_payload_o), .load_type_o(load_type_o),
      .input_load_number_o(input_load_number_o), .layer_number_o(layer_number_o),
      .weight_number_o(weight_number_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_run();
      for (int l = 0; l < 8; l++)
         for (int r = 0; r < 16; r++) begin
            if (l == 0)
               for (int k = 0; k < 8; k++) begin
                  exp_q.push_back(beat_t'({in_mem[r*8+k], 1'b1, 4'(r), 3'd0, 3'd0}));
                  rd_q.push_back(rd_t'({1'b1, 10'(r*8+k)}));
               end
            for (int w = 0; w < 8; w++) begin
               exp_q.push_back(beat_t'({wt_mem[l*128+r*8+w], 1'b0, 4'(r), 3'(l), 3'(w)}));
               rd_q.push_back(rd_t'({1'b0, 10'(l*128+r*8+w)}));
            end
         end
   endtask

   task automatic tick();
      beat_t e, o;
      rd_t   a, ra;
      @(posedge clk);
      #1;
      cyc++;
      if (in_rd_en_o | wt_rd_en_o) begin
         chk("single_rd_en", 64'(in_rd_en_o & wt_rd_en_o), 64'd0);
         chk("rd_q_nonempty", 64'(rd_q.size() != 0), 64'd1);
         if (rd_q.size() != 0) begin
            a  = rd_q.pop_front();
            ra = {in_rd_en_o, in_rd_en_o ? {3'd0, in_rd_addr_o} : wt_rd_addr_o};
            chk("rd_addr", 64'(ra), 64'(a));
         end
         case (rd_idx)
            255:  chk("rd255_addr", 64'(wt_rd_addr_o), 64'd127);
            256:  chk("rd256_addr", 64'(wt_rd_addr_o), 64'd128);
            1151: chk("rd1151_addr", 64'(wt_rd_addr_o), 64'd1023);
            default: ;
         endcase
         rd_idx++;
      end
      if (load_en_o) begin
         chk("exp_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = {load_payload_o, load_type_o, input_load_number_o, layer_number_o, weight_number_o};
            chk("beat", 64'(o), 64'(e));
         end
         case (beat_idx)
            0:    chk("beat0", 64'({load_type_o, input_load_number_o, layer_number_o}), 64'({1'b1, 4'd0, 3'd0}));
            16:   chk("beat16", 64'({load_type_o, input_load_number_o}), 64'({1'b1, 4'd1}));
            255:  chk("beat255", 64'({layer_number_o, input_load_number_o, weight_number_o}), 64'({3'd0, 4'd15, 3'd7}));
            256:  chk("beat256", 64'({load_type_o, layer_number_o, input_load_number_o, weight_number_o}), 64'({1'b0, 3'd1, 4'd0, 3'd0}));
            1151: chk("beat1151", 64'({layer_number_o, input_load_number_o, weight_number_o}), 64'({3'd7, 4'd15, 3'd7}));
            default: ;
         endcase
         if (beat_idx == 0) first_cyc = cyc;
         beat_idx++;
      end else
         chk("idle_outputs", 64'({load_payload_o, load_type_o, weight_number_o}), 64'd0);
      if (done_o) begin
         done_seen = 1'b1;
         done_cyc  = cyc;
         chk("busy_at_done", 64'(busy_o), 64'd0);
      end
   endtask

   task automatic start_run();
      push_run();
      beat_idx  = 0;
      rd_idx    = 0;
      done_seen = 1'b0;
      start_i   = 1'b1;
      tick();
      start_i = 1'b0;
      t0      = cyc;
      chk("busy_after_start", 64'(busy_o), 64'd1);
   endtask

   task automatic wait_done(input bit poke);
      for (int i = 0; i < 1300 && !done_seen; i++) begin
         start_i = poke && (beat_idx == 5 || beat_idx == 600);
         tick();
      end
      start_i = 1'b0;
      chk("done_seen", 64'(done_seen), 64'd1);
      chk("first_beat_latency", 64'(first_cyc - t0), 64'd2);
      chk("done_latency", 64'(done_cyc - t0), 64'd1154);
      chk("beat_count", 64'(beat_idx), 64'd1152);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("hold_layer_row", 64'({layer_number_o, input_load_number_o}), 64'({3'd7, 4'd15}));
   endtask

   initial begin
      foreach (in_mem[i]) in_mem[i] = $urandom;
      foreach (wt_mem[i]) wt_mem[i] = $urandom;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy_done", 64'({busy_o, done_o}), 64'd0);
      chk("reset_rd_en", 64'({in_rd_en_o, wt_rd_en_o, in_rd_addr_o, wt_rd_addr_o}), 64'd0);
      chk("reset_load", 64'({load_en_o, load_payload_o, load_type_o, input_load_number_o, layer_number_o, weight_number_o}), 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      // run 1 with ignored start pulses, run 2 started during the done cycle
      start_run();
      wait_done(1'b1);
      start_run();
      wait_done(1'b0);
      repeat (5) tick();
      // run 3 aborted by reset at beat 400
      start_run();
      for (int i = 0; i < 1300 && beat_idx != 400; i++) tick();
      chk("reached_beat400", 64'(beat_idx), 64'd400);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_load", 64'({load_en_o, load_payload_o, load_type_o, weight_number_o}), 64'd0);
      chk("abort_busy_rd", 64'({busy_o, done_o, in_rd_en_o, wt_rd_en_o}), 64'd0);
      exp_q.delete();
      rd_q.delete();
      done_seen = 1'b0;
      repeat (20) tick();
      #2;
      rst_n = 1'b1;
      repeat (20) tick();
      chk("no_done_after_abort", 64'(done_seen), 64'd0);
      // run 4: full run from row 0 after reset release
      start_run();
      wait_done(1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
